// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SHIFT,
    S_ACK,
    S_WAIT_REL
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [3:0]    bitcnt, bitcnt_d;
  logic [9:0]    frame, frame_d;
  logic          data_oe_q, data_oe_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic clk_s1, clk_s2, clk_prev, fall;
  logic data_s1, data_s2;

  // Lines idle high, so the synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      fall     <= 1'b0;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      fall     <= clk_prev & ~clk_s2;
      data_s1  <= ps2_data_in;
      data_s2  <= data_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bitcnt    <= '0;
      frame     <= '0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      bitcnt    <= bitcnt_d;
      frame     <= frame_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bitcnt_d  = bitcnt;
    frame_d   = frame;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state)
      S_IDLE: begin
        data_oe_d = 1'b0;
        if (tx_valid) begin
          frame_d = {1'b1, ~^tx_data, tx_data};
          cnt_d   = '0;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt == INH_LAST) begin
          data_oe_d = 1'b1;
          state_d   = S_REQ;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      S_REQ: begin
        bitcnt_d = '0;
        cnt_d    = '0;
        state_d  = S_SHIFT;
      end
      S_SHIFT, S_ACK, S_WAIT_REL: begin
        // Timeout wins over any ack or release seen in the same cycle.
        if (cnt == TO_LAST) begin
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          frame_d   = '0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt + CW'(1);
          case (state)
            S_SHIFT: begin
              if (fall) begin
                if (bitcnt <= 4'd8) data_oe_d = ~frame[bitcnt];
                else                data_oe_d = 1'b0;
                bitcnt_d = bitcnt + 4'd1;
                if (bitcnt == 4'd9) state_d = S_ACK;
              end
            end
            S_ACK: begin
              if (fall) begin
                if (data_s2) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
                end else begin
                  state_d = S_WAIT_REL;
                end
              end
            end
            default: begin
              if (clk_s2 && data_s2) begin
                done_d  = 1'b1;
                state_d = S_IDLE;
              end
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx_ready    = (state == S_IDLE);
  assign busy        = ~tx_ready;
  assign tx_done     = done_q;
  assign tx_err      = err_q;
  assign ps2_clk_oe  = (state == S_INHIBIT) || (state == S_REQ);
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

  logic       clk;
  logic       rst_n;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, tx_done, tx_err, busy;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low, dev_data_low;
  wire logic  ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  wire logic  ps2_data_line = ~(ps2_data_oe | dev_data_low);

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       is_err;
    logic       chk;
    logic [7:0] data;
    logic       par;
  } exp_t;
  exp_t exp_q[$];

  int         dev_mode;
  int         dev_frames;
  int         dev_bit;
  logic       dev_abort;
  logic [9:0] dev_bits;
  logic [9:0] dev_frame;

  ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(2000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .busy       (busy),
    .ps2_clk_in (ps2_clk_line),
    .ps2_data_in(ps2_data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Device model: 40-cycle clock, samples host data on rising edges.
  task automatic dev_wait(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (!rst_n) dev_abort = 1'b1;
    end
  endtask

  initial begin
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
    dev_frames = 0; dev_bit = 0; dev_abort = 1'b0;
    dev_bits = '0; dev_frame = '0;
    forever begin
      @(posedge clk); #1;
      if (!ps2_clk_line) begin
        while (!ps2_clk_line) begin @(posedge clk); #1; end
        if (!ps2_data_line && dev_mode != 2) begin
          dev_abort = 1'b0;
          dev_bit = 0;
          dev_wait(10);
          for (int k = 1; k <= 11 && !dev_abort; k++) begin
            dev_clk_low = 1'b1;
            dev_wait(20);
            if (k <= 10) begin
              dev_bits[k-1] = ps2_data_line;
              dev_bit = k;
            end
            dev_clk_low = 1'b0;
            if (k == 10 && !dev_abort) begin
              dev_frame = dev_bits;
              dev_frames++;
            end
            dev_wait(5);
            if (k == 10 && dev_mode == 0 && !dev_abort) dev_data_low = 1'b1;
            if (k == 11) dev_data_low = 1'b0;
            dev_wait(15);
          end
          dev_clk_low = 1'b0;
          dev_data_low = 1'b0;
          dev_bit = 0;
        end
      end
    end
  end

  // Monitor: pops one expectation per completion pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (tx_done || tx_err) begin
        check("pulse_exclusive", {31'd0, tx_done & tx_err}, 0);
        check("ready_at_pulse", {31'd0, tx_ready}, 1);
        check("oe_released_at_pulse", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
        check("pulse_expected", {31'd0, exp_q.size() != 0}, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("pulse_kind_err", {31'd0, tx_err}, {31'd0, e.is_err});
          if (e.chk) begin
            check("frame_byte", {24'd0, dev_frame[7:0]}, {24'd0, e.data});
            check("frame_parity", {31'd0, dev_frame[8]}, {31'd0, e.par});
            check("frame_stop", {31'd0, dev_frame[9]}, 1);
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic push, input logic is_err,
                      input logic chk, input logic par);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!tx_ready && n < 5000) begin @(posedge clk); #1; n++; end
    check("ready_before_send", {31'd0, tx_ready}, 1);
    if (push) exp_q.push_back('{is_err, chk, d, par});
    tx_valid = 1'b1;
    tx_data  = d;
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 5000) begin @(negedge clk); n++; end
    check("idle_reached", {31'd0, busy}, 0);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    int hi, first_d, rdy_bad, s_idx, e_idx, f0, n;
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; dev_mode = 0;
    repeat (3) @(negedge clk);
    check("reset_tx_ready", {31'd0, tx_ready}, 1);
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_tx_done", {31'd0, tx_done}, 0);
    check("reset_tx_err", {31'd0, tx_err}, 0);
    check("reset_clk_oe", {31'd0, ps2_clk_oe}, 0);
    check("reset_data_oe", {31'd0, ps2_data_oe}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 0xF4 with inhibit/request timing measured from the accept edge.
    send(8'hF4, 1'b1, 1'b0, 1'b1, 1'b0);
    hi = 0; first_d = -1; rdy_bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_ready) rdy_bad = 1;
      if (!ps2_clk_oe) break;
      if (ps2_data_oe && first_d < 0) first_d = i;
      hi++;
    end
    check("inhibit_clk_oe_cycles", hi, 21);
    check("req_data_oe_index", first_d, 20);
    check("start_bit_held", {31'd0, ps2_data_oe}, 1);
    check("ready_low_during_inhibit", rdy_bad, 0);
    wait_idle();

    send(8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_idle();
    send(8'hFF, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_idle();

    // Device withholds ack.
    dev_mode = 1;
    send(8'hF4, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_idle();
    check("noack_clk_oe", {31'd0, ps2_clk_oe}, 0);
    check("noack_data_oe", {31'd0, ps2_data_oe}, 0);

    // Device never clocks: timeout counted from SHIFT entry.
    dev_mode = 2;
    send(8'hF4, 1'b1, 1'b1, 1'b0, 1'b0);
    s_idx = -1; e_idx = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (s_idx < 0 && !ps2_clk_oe && ps2_data_oe) s_idx = i;
      if (tx_err) begin e_idx = i; break; end
    end
    check("timeout_seen", {31'd0, (s_idx >= 0) && (e_idx >= 0)}, 1);
    check("timeout_latency", e_idx - s_idx, 2000);
    wait_idle();
    dev_mode = 0;

    // Reset during bit 4.
    send(8'hF4, 1'b0, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (dev_bit != 4 && n < 3000) begin @(negedge clk); n++; end
    check("reached_bit4", dev_bit, 4);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midreset_clk_oe", {31'd0, ps2_clk_oe}, 0);
    check("midreset_data_oe", {31'd0, ps2_data_oe}, 0);
    check("midreset_busy", {31'd0, busy}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (150) @(negedge clk);

    // Request while busy is dropped.
    f0 = dev_frames;
    send(8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    tx_valid = 1'b1;
    tx_data  = 8'hAA;
    repeat (5) @(posedge clk);
    #1 tx_valid = 1'b0;
    wait_idle();
    repeat (100) @(negedge clk);
    check("single_frame_observed", dev_frames - f0, 1);
    check("scoreboard_empty_end", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
